// File: rtl/integer_writeback_pkg.sv
// integer_writeback_pkg: shared datapath types and the writeback buffer entry layout
package integer_writeback_pkg;

    localparam int ROB_ID_W     = 6;
    localparam int INT_WB_DEPTH = 2;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [31:0]         reg_data_t;
    typedef logic [31:0]         addr_t;

    typedef struct packed {
        rob_id_t   rob_id;
        logic      dst_valid;
        reg_data_t dst;
        logic      br_wb_valid;
        addr_t     npc;
        logic      br_mispred;
    } int_wb_entry_t;

endpackage

// File: rtl/int_wb_fifo.sv
// int_wb_fifo: in-order storage for writeback entries with push/pop/flush and full/empty status
module int_wb_fifo
    import integer_writeback_pkg::*;
#(
    parameter int DEPTH = INT_WB_DEPTH
) (
    input  logic          clk,
    input  logic          rst_aL,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  int_wb_entry_t din,
    output int_wb_entry_t dout,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    int_wb_entry_t mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign dout    = mem[head];

    // Pointer and occupancy tracking; flush empties the buffer regardless of traffic
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop) head <= head + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage, cleared on reset so an empty buffer presents all-zero fields
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[tail] <= din;
        end
    end

endmodule

// File: rtl/integer_writeback.sv
// integer_writeback: buffers execute results, drives the shared ROB writeback port and the tag broadcast
// Optional zero-latency bypass when the buffer is empty: define INT_WB_BYPASS_EN
module integer_writeback
    import integer_writeback_pkg::*;
#(
    parameter int DEPTH = INT_WB_DEPTH
) (
    input  logic      clk,
    input  logic      rst_aL,
    input  logic      flush,
    input  logic      ex_valid,
    output logic      ex_ready,
    input  rob_id_t   ex_rob_id,
    input  logic      ex_dst_valid,
    input  reg_data_t ex_dst,
    input  logic      ex_br_wb_valid,
    input  addr_t     ex_npc,
    input  logic      ex_br_mispred,
    output logic      rob_wb_valid,
    input  logic      rob_wb_ready,
    output rob_id_t   rob_wb_rob_id,
    output logic      rob_wb_dst_valid,
    output reg_data_t rob_wb_dst,
    output logic      rob_wb_br_valid,
    output addr_t     rob_wb_npc,
    output logic      rob_wb_br_mispred,
    output logic      bcast_valid,
    output rob_id_t   bcast_rob_id,
    output reg_data_t bcast_dst
);

    int_wb_entry_t ex_entry;
    int_wb_entry_t head_entry;
    int_wb_entry_t out_entry;
    logic          full;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;

    assign ex_entry = '{
        rob_id:      ex_rob_id,
        dst_valid:   ex_dst_valid,
        dst:         ex_dst,
        br_wb_valid: ex_br_wb_valid,
        npc:         ex_npc,
        br_mispred:  ex_br_mispred
    };

    int_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_aL (rst_aL),
        .flush  (flush),
        .push   (push),
        .pop    (pop),
        .din    (ex_entry),
        .dout   (head_entry),
        .full   (full),
        .empty  (empty)
    );

    // Select the ROB port source and decide what enters and leaves the buffer
    always_comb begin
`ifdef INT_WB_BYPASS_EN
        bypass = empty & ex_valid & !flush;
`else
        bypass = 1'b0;
`endif
        out_entry    = bypass ? ex_entry : head_entry;
        ex_ready     = !full;
        rob_wb_valid = !empty | bypass;
        push         = ex_valid & !full & !(bypass & rob_wb_ready);
        pop          = rob_wb_valid & rob_wb_ready & !bypass;
    end

    // ROB write fields and the handshake-qualified tag broadcast
    always_comb begin
        rob_wb_rob_id     = out_entry.rob_id;
        rob_wb_dst_valid  = out_entry.dst_valid;
        rob_wb_dst        = out_entry.dst;
        rob_wb_br_valid   = out_entry.br_wb_valid;
        rob_wb_npc        = out_entry.npc;
        rob_wb_br_mispred = out_entry.br_mispred;
        bcast_valid       = rob_wb_valid & rob_wb_ready & out_entry.dst_valid;
        bcast_rob_id      = out_entry.rob_id;
        bcast_dst         = out_entry.dst;
    end

endmodule

// File: tb/tb_integer_writeback.sv
// tb_integer_writeback: directed self-checking bench for integer_writeback (DEPTH = 2)
module tb_integer_writeback;
    import integer_writeback_pkg::*;

    logic      clk = 1'b0;
    logic      rst_aL;
    logic      flush;
    logic      ex_valid;
    logic      ex_ready;
    rob_id_t   ex_rob_id;
    logic      ex_dst_valid;
    reg_data_t ex_dst;
    logic      ex_br_wb_valid;
    addr_t     ex_npc;
    logic      ex_br_mispred;
    logic      rob_wb_valid;
    logic      rob_wb_ready;
    rob_id_t   rob_wb_rob_id;
    logic      rob_wb_dst_valid;
    reg_data_t rob_wb_dst;
    logic      rob_wb_br_valid;
    addr_t     rob_wb_npc;
    logic      rob_wb_br_mispred;
    logic      bcast_valid;
    rob_id_t   bcast_rob_id;
    reg_data_t bcast_dst;

    int checks = 0;
    int failures = 0;

    integer_writeback dut (
        .clk               (clk),
        .rst_aL            (rst_aL),
        .flush             (flush),
        .ex_valid          (ex_valid),
        .ex_ready          (ex_ready),
        .ex_rob_id         (ex_rob_id),
        .ex_dst_valid      (ex_dst_valid),
        .ex_dst            (ex_dst),
        .ex_br_wb_valid    (ex_br_wb_valid),
        .ex_npc            (ex_npc),
        .ex_br_mispred     (ex_br_mispred),
        .rob_wb_valid      (rob_wb_valid),
        .rob_wb_ready      (rob_wb_ready),
        .rob_wb_rob_id     (rob_wb_rob_id),
        .rob_wb_dst_valid  (rob_wb_dst_valid),
        .rob_wb_dst        (rob_wb_dst),
        .rob_wb_br_valid   (rob_wb_br_valid),
        .rob_wb_npc        (rob_wb_npc),
        .rob_wb_br_mispred (rob_wb_br_mispred),
        .bcast_valid       (bcast_valid),
        .bcast_rob_id      (bcast_rob_id),
        .bcast_dst         (bcast_dst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int id, input logic dv, input logic [31:0] d,
                         input logic bv, input logic [31:0] npc, input logic mp);
        ex_valid       = v;
        ex_rob_id      = rob_id_t'(id);
        ex_dst_valid   = dv;
        ex_dst         = d;
        ex_br_wb_valid = bv;
        ex_npc         = npc;
        ex_br_mispred  = mp;
    endtask

    task automatic push(input int id, input logic [31:0] d);
        drive(1'b1, id, 1'b1, d, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_aL = 1'b0;
        flush = 1'b0;
        rob_wb_ready = 1'b0;
        idle();
        #1;
        chk("reset_ex_ready", ex_ready, 1);
        chk("reset_rob_wb_valid", rob_wb_valid, 0);
        chk("reset_bcast_valid", bcast_valid, 0);
        chk("reset_rob_id", rob_wb_rob_id, 0);
        chk("reset_dst", rob_wb_dst, 0);
        step();
        rst_aL = 1'b1;

`ifndef INT_WB_BYPASS_EN
        // single result, one-cycle latency, broadcast on handshake
        step(); push(5, 32'h0000_00AA); rob_wb_ready = 1'b1; #1;
        chk("t1_not_yet_visible", rob_wb_valid, 0);
        step(); idle(); #1;
        chk("t1_valid", rob_wb_valid, 1);
        chk("t1_rob_id", rob_wb_rob_id, 5);
        chk("t1_dst", rob_wb_dst, 32'hAA);
        chk("t1_bcast_valid", bcast_valid, 1);
        chk("t1_bcast_id", bcast_rob_id, 5);
        chk("t1_bcast_dst", bcast_dst, 32'hAA);
        step(); #1;
        chk("t1_drained", rob_wb_valid, 0);
        chk("t1_ex_ready", ex_ready, 1);
`else
        // bypass: empty buffer, result goes straight to the ROB port
        step(); push(9, 32'h0000_0099); rob_wb_ready = 1'b1; #1;
        chk("byp_valid", rob_wb_valid, 1);
        chk("byp_rob_id", rob_wb_rob_id, 9);
        chk("byp_dst", rob_wb_dst, 32'h99);
        chk("byp_bcast_valid", bcast_valid, 1);
        chk("byp_bcast_id", bcast_rob_id, 9);
        step(); idle(); #1;
        chk("byp_fifo_empty", rob_wb_valid, 0);
        chk("byp_ex_ready", ex_ready, 1);
`endif

        // fill under backpressure, then drain in order
        step(); rob_wb_ready = 1'b0; push(1, 32'h11);
        step(); push(2, 32'h22); #1;
        chk("t2_ready_one_entry", ex_ready, 1);
        chk("t2_head_id1", rob_wb_rob_id, 1);
        chk("t2_no_bcast_blocked", bcast_valid, 0);
        step(); idle(); rob_wb_ready = 1'b1; #1;
        chk("t2_full_ex_ready", ex_ready, 0);
        chk("t2_first_id", rob_wb_rob_id, 1);
        chk("t2_first_bcast", bcast_valid, 1);
        chk("t2_first_bcast_dst", bcast_dst, 32'h11);
        step(); #1;
        chk("t2_second_valid", rob_wb_valid, 1);
        chk("t2_second_id", rob_wb_rob_id, 2);
        chk("t2_second_dst", bcast_dst, 32'h22);
        chk("t2_ready_after_pop", ex_ready, 1);
        step(); rob_wb_ready = 1'b0; #1;
        chk("t2_empty", rob_wb_valid, 0);

        // full with ready: push blocked, next cycle push+pop together
        step(); push(3, 32'h33);
        step(); push(4, 32'h44);
        step(); push(6, 32'h66); rob_wb_ready = 1'b1; #1;
        chk("t3_full", ex_ready, 0);
        chk("t3_head3", rob_wb_rob_id, 3);
        step(); #1;
        chk("t3_after_pop_ready", ex_ready, 1);
        chk("t3_head4", rob_wb_rob_id, 4);
        step(); idle(); rob_wb_ready = 1'b0; #1;
        chk("t3_count1_valid", rob_wb_valid, 1);
        chk("t3_count1_ready", ex_ready, 1);
        chk("t3_head6", rob_wb_rob_id, 6);
        chk("t3_dst6", rob_wb_dst, 32'h66);
        step(); rob_wb_ready = 1'b1;
        step(); rob_wb_ready = 1'b0; #1;
        chk("t3_only_one_left", rob_wb_valid, 0);

        // branch-type result: br fields written, no broadcast
        step(); drive(1'b1, 7, 1'b0, 32'h55, 1'b1, 32'h0000_1040, 1'b1);
        step(); idle(); rob_wb_ready = 1'b1; #1;
        chk("t4_valid", rob_wb_valid, 1);
        chk("t4_rob_id", rob_wb_rob_id, 7);
        chk("t4_dst_valid", rob_wb_dst_valid, 0);
        chk("t4_br_valid", rob_wb_br_valid, 1);
        chk("t4_npc", rob_wb_npc, 32'h0000_1040);
        chk("t4_mispred", rob_wb_br_mispred, 1);
        chk("t4_no_bcast", bcast_valid, 0);
        step(); rob_wb_ready = 1'b0; #1;
        chk("t4_drained", rob_wb_valid, 0);

        // flush with two buffered and a same-cycle enqueue
        step(); push(10, 32'hA0);
        step(); push(11, 32'hB0);
        step(); push(12, 32'hC0); flush = 1'b1; #1;
        chk("t5_pre_flush_valid", rob_wb_valid, 1);
        step(); idle(); flush = 1'b0; #1;
        chk("t5_flushed_valid", rob_wb_valid, 0);
        chk("t5_flushed_ready", ex_ready, 1);
        step(); #1;
        chk("t5_new_entry_absent", rob_wb_valid, 0);

        // flush coinciding with a handshake still broadcasts
        step(); push(13, 32'hD0);
        step(); idle(); rob_wb_ready = 1'b1; flush = 1'b1; #1;
        chk("t5_flush_hs_bcast", bcast_valid, 1);
        chk("t5_flush_hs_id", bcast_rob_id, 13);
        step(); flush = 1'b0; rob_wb_ready = 1'b0; #1;
        chk("t5_flush_hs_empty", rob_wb_valid, 0);

        // asynchronous reset mid-stream
        step(); push(14, 32'hE0);
        step(); push(15, 32'hF0);
        step(); idle(); #1;
        chk("t6_full_before_reset", ex_ready, 0);
        #1 rst_aL = 1'b0;
        #1;
        chk("t6_reset_valid", rob_wb_valid, 0);
        chk("t6_reset_ready", ex_ready, 1);
        chk("t6_reset_id", rob_wb_rob_id, 0);
        chk("t6_reset_dst", rob_wb_dst, 0);
        step(); rst_aL = 1'b1;
        step(); #1;
        chk("t6_stays_empty", rob_wb_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/integer_writeback.md
Name: integer_writeback

Overview:
- Receives one result per cycle from the integer execute stage and buffers it in a small in-order FIFO.
- Drives the ROB integer writeback port, which is shared with the LSU through an external arbiter, so the port can be backpressured.
- On each ROB write handshake with a destination, drives the tag/data broadcast to the IIQ, LSQ and dispatch/issue bypass capture.
- Applies backpressure to the issue stage through ex_ready.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst_aL  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush from ROB (mispredict recovery), synchronous
- ex_valid  in  1  execute result valid
- ex_ready  out  1  writeback can accept a result this cycle
- ex_rob_id  in  rob_id_t  result ROB id
- ex_dst_valid  in  1  result has a register destination (0 for B-type)
- ex_dst  in  reg_data_t  result data
- ex_br_wb_valid  in  1  npc/br_mispred meaningful (B-type or jalr)
- ex_npc  in  addr_t  next pc
- ex_br_mispred  in  1  misprediction flag
- rob_wb_valid  out  1  ROB write request
- rob_wb_ready  in  1  ROB port granted this cycle
- rob_wb_rob_id  out  rob_id_t  ROB index
- rob_wb_dst_valid  out  1  write dst into ROB
- rob_wb_dst  out  reg_data_t  data
- rob_wb_br_valid  out  1  write pc_npc and br_mispred
- rob_wb_npc  out  addr_t  next pc
- rob_wb_br_mispred  out  1  misprediction flag
- bcast_valid  out  1  tag broadcast valid
- bcast_rob_id  out  rob_id_t  broadcast tag
- bcast_dst  out  reg_data_t  broadcast data

Behaviour:
- Reset (rst_aL low, asynchronous):
  - Head, tail and count cleared to 0.
  - All outputs 0, except ex_ready = 1.
  - Reset mid-operation discards all buffered entries immediately.
- Enqueue: ex_valid & ex_ready at rising edge N writes the entry at tail; tail increments modulo DEPTH.
- Dequeue: rob_wb_valid & rob_wb_ready at edge N pops the head; head increments modulo DEPTH.
- ex_ready = (count != DEPTH). It depends on registered state only, never on rob_wb_ready.
- Output port:
  - rob_wb_valid = (count != 0); all rob_wb_* fields come from the head entry.
  - Latency: an entry enqueued at edge N is visible on rob_wb_* in cycle N+1.
  - rob_wb_valid holds and fields stay stable until the handshake completes.
- Broadcast:
  - bcast_valid = rob_wb_valid & rob_wb_ready & rob_wb_dst_valid; bcast_rob_id/bcast_dst mirror the head entry.
  - This is combinational on the handshake, so it is seen in the same cycle as the ROB write.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Legal when full: ex_ready is 0, so no enqueue occurs that cycle.
- Empty: rob_wb_valid = 0; bcast_valid = 0.
- Full: ex_ready = 0. An ex_valid presented while full is the issuer's protocol violation and is ignored.
- Flush, synchronous at the edge:
  - Count, head and tail reset to 0; any same-cycle enqueue is dropped.
  - A same-cycle ROB handshake still counts as completed to the ROB, and its broadcast is still driven.
  - Flush dominates every other state update.
- Stored entry = {rob_id, dst_valid, dst, br_wb_valid, npc, br_mispred}, 1 + 32 + 1 + 32 + 1 + rob_id bits. No arithmetic beyond pointer wrap.
- Pointers are log2(DEPTH) bits; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: INT_WB_BYPASS_EN.
- Defined:
  - When count == 0 and ex_valid & !flush, the ex_* fields drive rob_wb_* combinationally and rob_wb_valid = 1.
  - If rob_wb_ready, the entry is not written into the FIFO (zero latency). Otherwise it is enqueued normally.
  - bcast_* follows the same rule.
- Undefined: every result passes through the FIFO, with 1-cycle minimum latency as above.

Decomposition:
- Shared package (global defs) adds:
  - int_wb_entry_t packed struct for the stored entry.
  - INT_WB_DEPTH constant.
- Uses existing rob_id_t, reg_data_t and addr_t.
- One sub-module is natural: int_wb_fifo, a parameterised storage/pointer/count block with push, pop, flush, full and empty. The top level holds the handshake, bypass and broadcast logic.

Test Plan:
- Reset, then one result (rob_id=5, dst=0x0000_00AA, dst_valid=1) with rob_wb_ready=1 → rob_wb_valid and bcast_valid high next cycle with id 5 and data 0xAA; count returns to 0.
- rob_wb_ready=0; push ids 1, 2 → ex_ready=0 after the 2nd push. Raise ready → ids 1 then 2 retire in order on consecutive cycles; ex_ready=1 after the first pop.
- Full FIFO with ready=1 and ex_valid=1 → no enqueue that cycle. Next cycle push/pop occur simultaneously and count stays 1.
- B-type result (dst_valid=0, br_wb_valid=1, npc=0x0000_1040, mispred=1) → ROB write shows br fields; bcast_valid stays 0.
- Two entries buffered, flush with ex_valid=1 → next cycle rob_wb_valid=0, ex_ready=1, new entry absent. Assert rst_aL low mid-stream → outputs 0 immediately.
- INT_WB_BYPASS_EN: empty, ex_valid, ready=1, id=9 → rob_wb_valid=1 with id 9 in the same cycle; FIFO stays empty.
